data_ram_responder: RTL
=======================

Name: data_ram_responder

Overview:
- Responder side of the MEM-stage data-memory bus: accepts chip-enable, write-enable, byte-select, address and write-data, and returns read data.
- Models a data RAM with configurable access latency. Raises a stall request to the pipeline controller until each access completes.
- Sits between the MEM stage and the data storage, replacing the zero-latency combinational RAM used so far.

Parameters:
- ADDR_W, 10, log2 of the number of 32-bit words stored. Default is 1024 words (4 KiB).
- LAT, 2, access latency in BUSY cycles. Legal range 1..15.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset rst, synchronous, active-high.
- mem_ce_i  input  1  request valid (chip enable). Held stable by initiator while stall_req_o=1.
- mem_we_i  input  1  1=write, 0=read.
- mem_sel_i  input  4  byte lanes. sel[3]=bits 31:24 (lowest byte address, big-endian) … sel[0]=bits 7:0.
- mem_addr_i  input  32  byte address. Bits [1:0] are ignored.
- mem_data_i  input  32  write data, already lane-aligned by the initiator.
- mem_data_o  output  32  read data. Valid while ack_o=1.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  out-of-range access. Valid with ack_o.
- stall_req_o  output  1  pipeline stall request.

Behaviour:
- FSM states:
  - IDLE:
    - mem_ce_i=1: latch we/sel/addr/data, load cnt=LAT-1, go to BUSY.
    - mem_ce_i=0: stay in IDLE.
  - BUSY:
    - mem_ce_i=0 (flush): go to IDLE, nothing committed.
    - cnt=0: commit the access and go to DONE.
    - otherwise: decrement cnt.
  - DONE: go to IDLE unconditionally. A new request is sampled in the following IDLE cycle.
- stall_req_o = mem_ce_i && (state==IDLE || state==BUSY). It is combinational, and low in DONE.
- Timing with LAT=1, request presented at cycle 0:
  - cycles 0–1: stall high.
  - cycle 2: ack_o=1, stall low.
  - Total occupancy per access is LAT+2 cycles.
- Range check: out-of-range iff latched addr[31:ADDR_W+2] != 0.
- Commit, write, in range: each word[idx] byte lane with sel bit =1 is replaced from the latched data. Other lanes are untouched. idx = addr[ADDR_W+1:2].
- Commit, write, sel=4'b0000: completes normally, ack asserted, storage unchanged.
- Commit, read: mem_data_o <= word[idx], full word regardless of sel. Byte extraction is the MEM stage's job.
- Commit, out of range:
  - no write;
  - read data = 0x00000000;
  - err_o=1 for the DONE cycle.
- mem_data_o is registered. It is updated only at read commit and holds its value otherwise. Writes do not change it.
- ack_o and err_o are registered and high only in DONE.
- Reset values: state=IDLE, cnt=0, mem_data_o=0, ack_o=0, err_o=0. stall_req_o follows mem_ce_i in IDLE.
- Storage contents are not reset.
- Reset during BUSY: any pending write is discarded.
- Latched request fields are ignored by the FSM while in BUSY/DONE. Changes on the inputs there have no effect.
- Read-after-write to the same address in back-to-back requests returns the new data, because the write committed in an earlier cycle.

Decomposition:
- Shared defines file additions:
  - DataMemAddrW;
  - DataMemLat;
  - state encodings DRAM_IDLE/DRAM_BUSY/DRAM_DONE (2 bits).
- Reuse the existing ZeroWord, ChipEnable, WriteEnable and RstEnable macros.
- One sub-module: dram_byte_array.
  - Four 8-bit lane arrays, synchronous write with per-lane enable.
  - Synchronous read port.
  - No reset.
- The FSM, counter and range check stay in data_ram_responder.

Test Plan:
- Full-word round trip, LAT=2: write addr 0x10, sel=4'b1111, data 0xDEADBEEF; then read addr 0x10.
  - stall high 3 cycles per access, ack on 4th;
  - read returns 0xDEADBEEF, err_o=0.
- Byte-lane write: preload 0x11223344 at 0x20, then write sel=4'b0100 data 0x00AA0000; read back.
  - returns 0x11AA3344.
  - sel=0000 write leaves 0x11AA3344 and still acks.
- Out of range, ADDR_W=10: write 0x1000 then read 0x1000.
  - both ack with err_o=1;
  - read data 0x00000000;
  - word 0 unchanged.
- Flush mid-access: write 0x30 data 0x12345678, drop mem_ce_i in the first BUSY cycle.
  - no ack;
  - returns to IDLE;
  - later read of 0x30 returns prior contents.
- Reset mid-access: assert rst during BUSY of a write.
  - next cycle state=IDLE, ack_o=0, mem_data_o=0;
  - write not committed.
- Back-to-back: mem_ce_i held high across 3 alternating write/read requests at 0x40.
  - exactly one ack per request, LAT+2 cycles apart;
  - read-after-write returns the freshly written value.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// Shared constants and state encoding for the MEM-stage data RAM responder.
// Imported by the responder top and its byte-lane storage.
package data_ram_responder_pkg;

  localparam int          DataMemAddrW = 10;
  localparam int          DataMemLat   = 2;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        ChipEnable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        RstEnable    = 1'b1;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'b00,
    DRAM_BUSY = 2'b01,
    DRAM_DONE = 2'b10
  } dram_state_e;

endpackage

// File: rtl/data_ram_responder_byte_array.sv
// Word storage as four independent 8-bit lanes: per-lane synchronous write,
// registered read of all lanes every cycle, no reset.
module dram_byte_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_lane [0:(1<<ADDR_W)-1];
    logic [7:0] r_q;

    // lane g holds bits 8g+7:8g of every word (lane 3 = lowest byte address)
    always_ff @(posedge clk) begin
      if (i_we[g]) begin
        r_lane[i_waddr] <= i_wdata[8*g +: 8];
      end
      r_q <= r_lane[i_raddr];
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/data_ram_responder.sv
// Latency-configurable data RAM responder: stalls the pipeline while an
// access is in flight, then pulses ack (with err for out-of-range) for one cycle.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_W = DataMemAddrW,
  parameter int LAT    = DataMemLat
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_req_o
);

  localparam logic [3:0] LatLoad = 4'(LAT - 1);

  dram_state_e r_state;
  dram_state_e w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_latch;
  logic        w_commit;

  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_mem_data;
  logic        r_ack;
  logic        r_err;

  logic              w_oor;
  logic              w_wr_commit;
  logic [3:0]        w_lane_we;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [31:0]       w_rdata;
  logic [1:0]        w_unused_addr;

  assign w_unused_addr = mem_addr_i[1:0];
  assign w_oor = (r_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});

  // Next-state, counter and commit decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      DRAM_IDLE: begin
        if (mem_ce_i == ChipEnable) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = LatLoad;
          w_state_nxt = DRAM_BUSY;
        end else begin
          w_state_nxt = DRAM_IDLE;
        end
      end
      DRAM_BUSY: begin
        if (mem_ce_i != ChipEnable) begin
          w_state_nxt = DRAM_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = DRAM_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      DRAM_DONE: begin
        w_state_nxt = DRAM_IDLE;
      end
      default: begin
        w_state_nxt = DRAM_IDLE;
      end
    endcase
  end

  // A reset coinciding with the commit edge must not let the write through
  assign w_wr_commit = w_commit && (r_we == WriteEnable) && !w_oor && (rst != RstEnable);
  assign w_lane_we   = {4{w_wr_commit}} & r_sel;

  // The array reads every cycle; the read issued from IDLE or BUSY lands by the commit edge
  assign w_rd_idx = (r_state == DRAM_IDLE) ? mem_addr_i[ADDR_W+1:2] : r_addr[ADDR_W+1:2];

  dram_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_lane_we),
    .i_waddr (r_addr[ADDR_W+1:2]),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata)
  );

  // FSM state, counter and registered response
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state    <= DRAM_IDLE;
      r_cnt      <= 4'd0;
      r_mem_data <= ZeroWord;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_commit;
      r_err   <= w_commit && w_oor;
      if (w_commit && (r_we != WriteEnable)) begin
        r_mem_data <= w_oor ? ZeroWord : w_rdata;
      end else begin
        r_mem_data <= r_mem_data;
      end
    end
  end

  // Request capture; fields are frozen until the FSM returns to IDLE
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_we    <= mem_we_i;
      r_sel   <= mem_sel_i;
      r_addr  <= mem_addr_i[31:2];
      r_wdata <= mem_data_i;
    end
  end

  assign mem_data_o  = r_mem_data;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign stall_req_o = mem_ce_i && ((r_state == DRAM_IDLE) || (r_state == DRAM_BUSY));

endmodule
